fetch_ctrl: RTL and testbench

- Consumer side of the PC register interface. Takes the registered fetch PC and issues reads to a variable-latency instruction memory using a req/ack handshake.
- Drives the stall back to the PC register until the instruction is accepted into the fetch/decode pipeline register, which this block owns.
- Handles decode back-pressure with a one-entry skid buffer, and handles taken-branch flushes, including fetches already in flight.

---
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues PC reads to a variable-latency imem over req/ack, owns the fetch/decode register.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush,
  input  logic               stall_d,
  output logic               stall_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_d,
  output logic [ADDR_W-1:0]  pc_d,
  output logic               valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_stall_cyc,
  output logic [15:0]        perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t             state, state_nx;
  logic               accept;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  assign imem_addr = pc_in;
  assign accept    = (state == FETCH) && imem_ack && !flush && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: begin
        if (flush)                    state_nx = imem_ack ? FETCH : DISCARD;
        else if (imem_ack && stall_d) state_nx = HOLD;
      end
      HOLD: begin
        if (flush || !stall_d) state_nx = FETCH;
      end
      DISCARD: begin
        if (flush)         state_nx = DISCARD;
        else if (imem_ack) state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // HOLD is the only state with a live skid entry, so it is also the only one without a request.
  always_comb begin
    imem_req = 1'b0;
    stall_pc = 1'b1;
    if (!reset) begin
      imem_req = (state != HOLD);
      stall_pc = !(accept || flush);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      valid_d    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (stall_d) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_in;
            end else begin
              instr_d <= imem_rdata;
              pc_d    <= pc_in;
              valid_d <= 1'b1;
            end
          end else if (!stall_d) begin
            valid_d <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_d) begin
            instr_d <= skid_instr;
            pc_d    <= skid_pc;
            valid_d <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc && perf_stall_cyc != 16'hFFFF) perf_stall_cyc <= perf_stall_cyc + 16'd1;
      if (flush && perf_flush_cnt != 16'hFFFF)    perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: randomized memory latency, stalls, flushes and resets against a queue/flag reference model.
module tb_fetch_ctrl;
  localparam int AW = 16;
  localparam int IW = 32;
  localparam logic [IW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          flush = 1'b0;
  logic          stall_d = 1'b0;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          stall_pc, imem_req, valid_d;
  logic [AW-1:0] imem_addr, pc_d;
  logic [IW-1:0] instr_d;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_stall_cyc, perf_flush_cnt;
  int            m_stall_cnt = 0;
  int            m_flush_cnt = 0;
`endif

  fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .stall_d(stall_d),
    .stall_pc(stall_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  // Reference model: one-slot pending queue plus a "squashed request still outstanding" flag.
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_instr = '0;
  logic [AW-1:0] m_pcd = '0;
  logic          m_skid_full = 1'b0;
  logic [IW-1:0] m_skid_dat = '0;
  logic [AW-1:0] m_skid_pc = '0;
  logic          m_squash = 1'b0;
  logic          req_e, stall_e, acc_e;
  int            lat_left = -1;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] pc_nx = '0;
  logic [AW-1:0] tgt = 16'h0040;

  function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : 32'h000000A0 + {16'h0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic fl, input logic st, input int lat, input logic rst);
    @(negedge clk);
    pc_in   = pc_nx;
    reset   = rst;
    flush   = fl;
    stall_d = st;
    if (rst) begin
      m_valid = 1'b0; m_pcd = '0; m_instr = NOP;
      m_skid_full = 1'b0; m_squash = 1'b0; lat_left = -1;
    end
    req_e = !rst && !m_skid_full;
    if (req_e && lat_left < 0) begin
      lat_left = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      req_addr = pc_in;
    end
    imem_ack   = req_e && (lat_left == 0);
    imem_rdata = imem_ack ? mem(req_addr) : $urandom;
    acc_e   = imem_ack && !m_squash && !fl;
    stall_e = rst || !(acc_e || fl);
    #1;
    chk("imem_req", {63'd0, imem_req}, {63'd0, req_e});
    chk("stall_pc", {63'd0, stall_pc}, {63'd0, stall_e});
    chk("imem_addr", {48'd0, imem_addr}, {48'd0, pc_in});
    chk("valid_d", {63'd0, valid_d}, {63'd0, m_valid});
    chk("instr_d", {32'd0, instr_d}, {32'd0, m_instr});
    chk("pc_d", {48'd0, pc_d}, {48'd0, m_pcd});
    @(posedge clk);
    if (rst) begin
`ifdef FETCH_PERF_EN
      m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    end else begin
`ifdef FETCH_PERF_EN
      if (stall_e && m_stall_cnt < 65535) m_stall_cnt++;
      if (fl && m_flush_cnt < 65535) m_flush_cnt++;
`endif
      if (fl) begin
        m_squash    = req_e && (m_squash || !imem_ack);
        m_skid_full = 1'b0;
        m_valid     = 1'b0;
        m_instr     = NOP;
      end else if (m_squash) begin
        if (imem_ack) m_squash = 1'b0;
      end else if (m_skid_full) begin
        if (!st) begin
          m_instr = m_skid_dat; m_pcd = m_skid_pc; m_valid = 1'b1; m_skid_full = 1'b0;
        end
      end else if (imem_ack) begin
        if (st) begin
          m_skid_full = 1'b1; m_skid_dat = imem_rdata; m_skid_pc = pc_in;
        end else begin
          m_instr = imem_rdata; m_pcd = pc_in; m_valid = 1'b1;
        end
      end else if (!st) begin
        m_valid = 1'b0;
      end
      if (imem_ack) lat_left = -1;
      else if (lat_left > 0) lat_left--;
      if (!stall_e) pc_nx = fl ? tgt : pc_in + 16'd1;
    end
  endtask

  initial begin
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    #1;
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_stall_pc", {63'd0, stall_pc}, 64'd1);
    chk("rst_valid_d", {63'd0, valid_d}, 64'd0);
    chk("rst_instr_d", {32'd0, instr_d}, 64'd0);

    // zero-wait stream, pc 0..3
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      #1;
      chk("zw_instr_d", {32'd0, instr_d}, 64'hA0 + 64'(i));
      chk("zw_pc_d", {48'd0, pc_d}, 64'(i));
    end

    // redirect to 0x10, then a 3-cycle fetch
    tgt = 16'h0010;
    step(1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("fl_valid_d", {63'd0, valid_d}, 64'd0);
    step(1'b0, 1'b0, 2, 1'b0);
    #1;
    chk("wait_valid_d", {63'd0, valid_d}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("wait_instr_d", {32'd0, instr_d}, 64'hDEADBEEF);
    chk("wait_pc_d", {48'd0, pc_d}, 64'h10);

    // decode stall on the pc-5 ack cycle
    tgt = 16'h0005;
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    #1;
    chk("hold_imem_req", {63'd0, imem_req}, 64'd0);
    chk("hold_instr_d", {32'd0, instr_d}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("skid_instr_d", {32'd0, instr_d}, 64'hA5);
    chk("skid_pc_d", {48'd0, pc_d}, 64'h5);
    step(1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("after_skid_instr_d", {32'd0, instr_d}, 64'hA6);

    // flush during a 4-cycle fetch
    tgt = 16'h0040;
    step(1'b0, 1'b0, 3, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("disc_valid_d", {63'd0, valid_d}, 64'd0);
    chk("disc_instr_d", {32'd0, instr_d}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("redir_instr_d", {32'd0, instr_d}, 64'hE0);
    chk("redir_pc_d", {48'd0, pc_d}, 64'h40);

    // reset in the middle of a wait
    step(1'b0, 1'b0, 3, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    #1;
    chk("midrst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_valid_d", {63'd0, valid_d}, 64'd0);
    chk("midrst_pc_d", {48'd0, pc_d}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b0);
    #1;
    chk("postrst_instr_d", {32'd0, instr_d}, 64'hE1);

    for (int n = 0; n < 3000; n++) begin
      logic fl, st, rs;
      fl = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 99) == 0);
      if (fl) tgt = 16'($urandom);
      step(fl, st, -1, rs);
    end

`ifdef FETCH_PERF_EN
    #1;
    chk("perf_stall_cyc", {48'd0, perf_stall_cyc}, 64'(m_stall_cnt));
    chk("perf_flush_cnt", {48'd0, perf_flush_cnt}, 64'(m_flush_cnt));
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
